// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial memory arbiter: access types, FSM states,
// default IO window base and read-data extension helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  ACC_WORD         = 2'b00;
  localparam logic [1:0]  ACC_HALF         = 2'b01;
  localparam logic [1:0]  ACC_BYTE         = 2'b10;
  localparam int          ACC_UNSIGNED_BIT = 2;
  localparam logic [31:0] MEM_IO_BASE      = 32'h0003_0000;

  function automatic logic [2:0] beat_count(input logic [1:0] acc);
    case (acc)
      ACC_WORD: beat_count = 3'd4;
      ACC_HALF: beat_count = 3'd2;
      default:  beat_count = 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] extend_read(input logic [31:0] raw, input logic [2:0] typ);
    logic sgn;
    sgn = 1'b0;
    case (typ[1:0])
      ACC_WORD: extend_read = raw;
      ACC_HALF: begin
        sgn = raw[15] & ~typ[ACC_UNSIGNED_BIT];
        extend_read = {{16{sgn}}, raw[15:0]};
      end
      default: begin
        sgn = raw[7] & ~typ[ACC_UNSIGNED_BIT];
        extend_read = {{24{sgn}}, raw[7:0]};
      end
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of the memory arbiter: per-port request fields in,
// grant/completion/read data out.
interface mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            req_in;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in;
  logic [NUM_PORTS*32-1:0]         wdata_in;
  logic [NUM_PORTS-1:0]            r_nw_in;
  logic [NUM_PORTS*3-1:0]          type_in;
  logic [NUM_PORTS-1:0]            grant_out;
  logic [NUM_PORTS-1:0]            done_out;
  logic [31:0]                     rdata_out;

  modport master (
    output req_in, addr_in, wdata_in, r_nw_in, type_in,
    input  grant_out, done_out, rdata_out
  );

  modport slave (
    input  req_in, addr_in, wdata_in, r_nw_in, type_in,
    output grant_out, done_out, rdata_out
  );
endinterface

// File: rtl/mem_arb_pick.sv
// One-hot requester selection. MEM_ARB_RR_EN selects round-robin with a
// next-start pointer; otherwise fixed priority, lowest index wins.
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PW        = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 accept,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        sel
);

`ifdef MEM_ARB_RR_EN
  localparam int SW = PW + 1;

  logic [PW-1:0] ptr_q;
  logic [SW-1:0] sum;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(NUM_PORTS)) sum = sum - SW'(NUM_PORTS);
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        sel         = cand;
      end
    end
  end

  // ptr_q holds the port where the next search begins
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr_q <= '0;
    end else if (accept) begin
      if (sel == PW'(NUM_PORTS - 1)) ptr_q <= '0;
      else                           ptr_q <= sel + 1'b1;
    end
  end
`else
  logic [PW-1:0] cand;
  logic          found;
  logic          unused_pick;

  assign unused_pick = ^{clk_in, rst_in, accept};

  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        sel         = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial memory controller arbitrating NUM_PORTS requesters onto an 8-bit bus.
// Arbitration policy chosen by MEM_ARB_RR_EN (round-robin) or fixed priority by default.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational
// XFER  | one byte beat per cycle; IO writes stall while the IO buffer is full
// WAIT  | read only: capture the final byte returned by memory
// DONE  | one-cycle done pulse with extended read data
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int                    NUM_PORTS  = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(MEM_IO_BASE)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  mem_arbiter_if.slave          req_bus,
  input  logic [7:0]            mem_read,
  output logic [7:0]            mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  r_nw_out,
  input  logic                  io_buffer_full
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t                  state_q, state_d;
  logic [PW-1:0]           port_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    r_nw_q;
  logic [2:0]              type_q;
  logic [1:0]              beat_q, beat_d;
  logic [31:0]             rbuf_q;

  logic [NUM_PORTS-1:0]    pick_grant;
  logic [PW-1:0]           pick_sel;
  logic                    accept;
  logic [2:0]              n_beats;
  logic                    last_beat;
  logic [1:0]              last_idx;
  logic [1:0]              prev_idx;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic                    stall;

  // Reset and rdy gating keep the grant silent even though it is combinational
  assign accept = rst_in && rdy_in && (state_q == ST_IDLE) && (|req_bus.req_in);
  assign req_bus.grant_out = accept ? pick_grant : '0;

  assign n_beats   = beat_count(type_q[1:0]);
  assign last_beat = ({1'b0, beat_q} == (n_beats - 3'd1));
  assign last_idx  = 2'(n_beats - 3'd1);
  assign prev_idx  = beat_q - 2'd1;
  assign beat_addr = addr_q + ADDR_WIDTH'(beat_q);
  assign stall     = (state_q == ST_XFER) && !r_nw_q && (beat_addr >= IO_BASE) && io_buffer_full;

  mem_arb_pick #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_pick (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .accept (accept),
    .req    (req_bus.req_in),
    .grant  (pick_grant),
    .sel    (pick_sel)
  );

  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    mem_addr          = '0;
    r_nw_out          = 1'b1;
    mem_write         = 8'h00;
    req_bus.done_out  = '0;
    req_bus.rdata_out = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_XFER;
          beat_d  = 2'd0;
        end
      end
      ST_XFER: begin
        mem_addr = beat_addr;
        if (!stall) begin
          r_nw_out  = r_nw_q;
          mem_write = r_nw_q ? 8'h00 : wdata_q[8*beat_q +: 8];
          if (last_beat) begin
            state_d = r_nw_q ? ST_WAIT : ST_DONE;
            beat_d  = 2'd0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      ST_WAIT: state_d = ST_DONE;
      ST_DONE: begin
        req_bus.done_out[port_q] = 1'b1;
        req_bus.rdata_out        = r_nw_q ? extend_read(rbuf_q, type_q) : 32'h0;
        state_d                  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      r_nw_q  <= 1'b0;
      type_q  <= '0;
      beat_q  <= '0;
      rbuf_q  <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        port_q  <= pick_sel;
        addr_q  <= req_bus.addr_in[pick_sel*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= req_bus.wdata_in[pick_sel*32 +: 32];
        r_nw_q  <= req_bus.r_nw_in[pick_sel];
        type_q  <= req_bus.type_in[pick_sel*3 +: 3];
        rbuf_q  <= '0;
      end
      // memory answers one cycle late, so each beat stores the previous beat's byte
      if (state_q == ST_XFER && r_nw_q && beat_q != 2'd0)
        rbuf_q[8*prev_idx +: 8] <= mem_read;
      if (state_q == ST_WAIT)
        rbuf_q[8*last_idx +: 8] <= mem_read;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, arbitration, read extension, IO stall,
// rdy freeze and mid-transaction reset, with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_read;
  logic [7:0]  mem_write;
  logic [31:0] mem_addr;
  logic        r_nw_out;
  logic        io_buffer_full;
  logic [7:0]  ram [0:255];

  int total;
  int bad;

  mem_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .req_bus        (bus),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .r_nw_out       (r_nw_out),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) mem_read <= ram[mem_addr[7:0]];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic rnw, input logic [2:0] t);
    bus.addr_in[p*32 +: 32]  = a;
    bus.wdata_in[p*32 +: 32] = d;
    bus.r_nw_in[p]           = rnw;
    bus.type_in[p*3 +: 3]    = t;
    bus.req_in[p]            = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    set_port(0, 32'h100, 32'h0, 1'b1, 3'b000);
    #1;
    total++;
    if (bus.grant_out !== 2'b00) begin
      bad++; $display("FAIL reset_grant got=%b exp=00", bus.grant_out);
    end
    total++;
    if ({mem_addr, r_nw_out, mem_write} !== {32'h0, 1'b1, 8'h00}) begin
      bad++; $display("FAIL reset_bus got=%h/%b/%h exp=0/1/0", mem_addr, r_nw_out, mem_write);
    end
    total++;
    if (bus.done_out !== 2'b00 || bus.rdata_out !== 32'h0) begin
      bad++; $display("FAIL reset_done got=%b/%h exp=00/0", bus.done_out, bus.rdata_out);
    end
    bus.req_in = '0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_arbitration();
    logic [1:0] g     [0:3];
    logic [1:0] exp_g [0:3];
    int n;
`ifdef MEM_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    for (int i = 0; i < 4; i++) g[i] = 2'b00;
    n = 0;
    tick();
    rst_in = 1'b0;
    #1;
    rst_in = 1'b1;
    set_port(0, 32'h50, 32'hA5, 1'b0, 3'b010);
    set_port(1, 32'h60, 32'h5A, 1'b0, 3'b010);
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (c > 0) tick();
      @(negedge clk_in);
      if (bus.grant_out !== 2'b00) begin
        g[n] = bus.grant_out;
        n++;
      end
    end
    tick();
    bus.req_in = '0;
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL arb_grant_count got=%0d exp=4", n);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g[i] !== exp_g[i]) begin
        bad++; $display("FAIL arb_grant_%0d got=%b exp=%b", i, g[i], exp_g[i]);
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_word_read();
    int done_c;
    logic [31:0] got;
    logic [1:0]  gp;
    done_c = -1; got = '0; gp = '0;
    tick();
    set_port(0, 32'h100, 32'h0, 1'b1, 3'b000);
    @(negedge clk_in);
    total++;
    if (bus.grant_out !== 2'b01) begin
      bad++; $display("FAIL word_rd_grant got=%b exp=01", bus.grant_out);
    end
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.req_in = '0;
      @(negedge clk_in);
      if (c <= 4) begin
        total++;
        if (mem_addr !== 32'h100 + c - 1 || r_nw_out !== 1'b1) begin
          bad++; $display("FAIL word_rd_addr_c%0d got=%h/%b exp=%h/1", c, mem_addr, r_nw_out, 32'h100 + c - 1);
        end
      end
      if (bus.done_out !== 2'b00) begin
        done_c = c; got = bus.rdata_out; gp = bus.done_out;
        break;
      end
    end
    total++;
    if (done_c !== 6 || gp !== 2'b01) begin
      bad++; $display("FAIL word_rd_done got=c%0d/%b exp=c6/01", done_c, gp);
    end
    total++;
    if (got !== 32'h4433_2211) begin
      bad++; $display("FAIL word_rd_data got=%h exp=44332211", got);
    end
  endtask

  task automatic test_extend();
    int          t_port [0:4];
    logic [31:0] t_addr [0:4];
    logic [2:0]  t_type [0:4];
    logic [31:0] t_exp  [0:4];
    int          t_cyc  [0:4];
    int done_c;
    logic [31:0] got;
    logic [1:0]  gp, ep;
    t_port[0] = 0; t_addr[0] = 32'h110; t_type[0] = 3'b010; t_exp[0] = 32'hFFFF_FF80; t_cyc[0] = 3;
    t_port[1] = 0; t_addr[1] = 32'h110; t_type[1] = 3'b110; t_exp[1] = 32'h0000_0080; t_cyc[1] = 3;
    t_port[2] = 0; t_addr[2] = 32'h120; t_type[2] = 3'b101; t_exp[2] = 32'h0000_80F0; t_cyc[2] = 4;
    t_port[3] = 1; t_addr[3] = 32'h120; t_type[3] = 3'b001; t_exp[3] = 32'hFFFF_80F0; t_cyc[3] = 4;
    t_port[4] = 1; t_addr[4] = 32'h120; t_type[4] = 3'b100; t_exp[4] = 32'h917F_80F0; t_cyc[4] = 6;
    for (int k = 0; k < 5; k++) begin
      done_c = -1; got = '0; gp = '0;
      ep = (t_port[k] == 0) ? 2'b01 : 2'b10;
      tick();
      set_port(t_port[k], t_addr[k], 32'h0, 1'b1, t_type[k]);
      for (int c = 1; c <= 10; c++) begin
        tick();
        bus.req_in = '0;
        @(negedge clk_in);
        if (bus.done_out !== 2'b00) begin
          done_c = c; got = bus.rdata_out; gp = bus.done_out;
          break;
        end
      end
      total++;
      if (done_c !== t_cyc[k] || gp !== ep) begin
        bad++; $display("FAIL ext_%0d_done got=c%0d/%b exp=c%0d/%b", k, done_c, gp, t_cyc[k], ep);
      end
      total++;
      if (got !== t_exp[k]) begin
        bad++; $display("FAIL ext_%0d_data got=%h exp=%h", k, got, t_exp[k]);
      end
    end
  endtask

  task automatic test_io_stall();
    logic [31:0] ea [1:7];
    logic        er [1:7];
    logic [7:0]  ew [1:7];
    int done_c;
    logic [31:0] got;
    logic [1:0]  gp;
    ea[1] = 32'h30000; er[1] = 1'b0; ew[1] = 8'hEF;
    ea[2] = 32'h30001; er[2] = 1'b1; ew[2] = 8'h00;
    ea[3] = 32'h30001; er[3] = 1'b1; ew[3] = 8'h00;
    ea[4] = 32'h30001; er[4] = 1'b1; ew[4] = 8'h00;
    ea[5] = 32'h30001; er[5] = 1'b0; ew[5] = 8'hBE;
    ea[6] = 32'h30002; er[6] = 1'b0; ew[6] = 8'hAD;
    ea[7] = 32'h30003; er[7] = 1'b0; ew[7] = 8'hDE;
    done_c = -1; got = 32'hFFFF_FFFF; gp = '0;
    tick();
    set_port(0, 32'h30000, 32'hDEAD_BEEF, 1'b0, 3'b000);
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus.req_in = '0;
      io_buffer_full = (c >= 2 && c <= 4);
      @(negedge clk_in);
      if (c <= 7) begin
        total++;
        if ({mem_addr, r_nw_out, mem_write} !== {ea[c], er[c], ew[c]}) begin
          bad++; $display("FAIL io_wr_c%0d got=%h/%b/%h exp=%h/%b/%h", c, mem_addr, r_nw_out, mem_write, ea[c], er[c], ew[c]);
        end
      end
      if (bus.done_out !== 2'b00) begin
        done_c = c; got = bus.rdata_out; gp = bus.done_out;
        break;
      end
    end
    io_buffer_full = 1'b0;
    total++;
    if (done_c !== 8 || gp !== 2'b01) begin
      bad++; $display("FAIL io_wr_done got=c%0d/%b exp=c8/01", done_c, gp);
    end
    total++;
    if (got !== 32'h0) begin
      bad++; $display("FAIL io_wr_rdata got=%h exp=0", got);
    end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] ea [1:6];
    int done_c;
    logic [31:0] got;
    ea[1] = 32'h130; ea[2] = 32'h130; ea[3] = 32'h130;
    ea[4] = 32'h131; ea[5] = 32'h132; ea[6] = 32'h133;
    done_c = -1; got = '0;
    tick();
    set_port(0, 32'h130, 32'h0, 1'b1, 3'b000);
    rdy_in = 1'b0;
    @(negedge clk_in);
    total++;
    if (bus.grant_out !== 2'b00) begin
      bad++; $display("FAIL rdy_low_grant got=%b exp=00", bus.grant_out);
    end
    tick();
    rdy_in = 1'b1;
    @(negedge clk_in);
    total++;
    if (bus.grant_out !== 2'b01 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL rdy_grant got=%b/%h exp=01/0", bus.grant_out, mem_addr);
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus.req_in = '0;
      rdy_in = !(c == 1 || c == 2);
      @(negedge clk_in);
      if (c <= 6) begin
        total++;
        if (mem_addr !== ea[c]) begin
          bad++; $display("FAIL rdy_addr_c%0d got=%h exp=%h", c, mem_addr, ea[c]);
        end
      end
      if (bus.done_out !== 2'b00) begin
        done_c = c; got = bus.rdata_out;
        break;
      end
    end
    rdy_in = 1'b1;
    total++;
    if (done_c !== 8) begin
      bad++; $display("FAIL rdy_done_cycle got=%0d exp=8", done_c);
    end
    total++;
    if (got !== 32'hD4C3_B2A1) begin
      bad++; $display("FAIL rdy_data got=%h exp=d4c3b2a1", got);
    end
  endtask

  task automatic test_reset_mid();
    int done_c;
    logic [31:0] got;
    logic [1:0]  gp;
    logic seen;
    done_c = -1; got = '0; gp = '0; seen = 1'b0;
    tick();
    set_port(1, 32'h40, 32'h1234_5678, 1'b0, 3'b000);
    @(negedge clk_in);
    total++;
    if (bus.grant_out !== 2'b10) begin
      bad++; $display("FAIL rstmid_grant got=%b exp=10", bus.grant_out);
    end
    tick();
    bus.req_in = '0;
    tick();
    tick();
    @(negedge clk_in);
    total++;
    if ({mem_addr, r_nw_out, mem_write} !== {32'h42, 1'b0, 8'h34}) begin
      bad++; $display("FAIL rstmid_beat2 got=%h/%b/%h exp=42/0/34", mem_addr, r_nw_out, mem_write);
    end
    rst_in = 1'b0;
    #1;
    total++;
    if ({mem_addr, r_nw_out, mem_write} !== {32'h0, 1'b1, 8'h00}) begin
      bad++; $display("FAIL rstmid_bus got=%h/%b/%h exp=0/1/0", mem_addr, r_nw_out, mem_write);
    end
    total++;
    if (bus.done_out !== 2'b00 || bus.grant_out !== 2'b00 || bus.rdata_out !== 32'h0) begin
      bad++; $display("FAIL rstmid_outs got=%b/%b/%h exp=00/00/0", bus.done_out, bus.grant_out, bus.rdata_out);
    end
    tick();
    rst_in = 1'b1;
    repeat (6) begin
      tick();
      @(negedge clk_in);
      if (bus.done_out !== 2'b00 || mem_addr !== 32'h0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rstmid_no_done got=%b exp=0", seen);
    end
    tick();
    set_port(1, 32'h110, 32'h0, 1'b1, 3'b010);
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.req_in = '0;
      @(negedge clk_in);
      if (bus.done_out !== 2'b00) begin
        done_c = c; got = bus.rdata_out; gp = bus.done_out;
        break;
      end
    end
    total++;
    if (done_c !== 3 || gp !== 2'b10 || got !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL rstmid_next got=c%0d/%b/%h exp=c3/10/ffffff80", done_c, gp, got);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk_in = 1'b0;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    io_buffer_full = 1'b0;
    bus.req_in   = '0;
    bus.addr_in  = '0;
    bus.wdata_in = '0;
    bus.r_nw_in  = '0;
    bus.type_in  = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h00] = 8'h11; ram[8'h01] = 8'h22; ram[8'h02] = 8'h33; ram[8'h03] = 8'h44;
    ram[8'h10] = 8'h80;
    ram[8'h20] = 8'hF0; ram[8'h21] = 8'h80; ram[8'h22] = 8'h7F; ram[8'h23] = 8'h91;
    ram[8'h30] = 8'hA1; ram[8'h31] = 8'hB2; ram[8'h32] = 8'hC3; ram[8'h33] = 8'hD4;

    test_reset();
    test_arbitration();
    test_word_read();
    test_extend();
    test_io_stall();
    test_rdy_freeze();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
